// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-bus responder backed by a byte-merged word RAM.
// Optional build macro DMEM_RANDLAT_EN adds LFSR-driven extra wait cycles per access.
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dreq,
  input  logic        dwrite,
  input  logic [31:0] daddr,
  input  logic [1:0]  dsize,
  inout  wire  [31:0] ddata,
  output logic        dready_n,
  output logic        dbusy,
  output logic        derr
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                  state_reg, state_next;
  logic [4:0]              cnt_reg, cnt_next;
  logic [4:0]              wait_total;
  logic                    accept;

  logic [31:0]             addr_reg, addr_next;
  logic [1:0]              size_reg, size_next;
  logic                    write_reg, write_next;
  logic [31:0]             wdata_reg, wdata_next;
  logic                    err_reg, err_next;
  logic [DEPTH_LOG2-1:0]   idx_reg, idx_next;
  logic [31:0]             off_next;

  logic                    dready_n_reg, dbusy_reg, derr_reg, drive_reg;
  logic                    resp_entry, commit;
  logic [3:0]              be;
  logic [31:0]             wlane;
  logic [31:0]             rd_word_reg;
  logic [31:0]             rdata;

  logic [31:0]             mem [DEPTH];

  assign accept = (state_reg == IDLE) && dreq;

`ifdef DMEM_RANDLAT_EN
  logic [15:0] lfsr_reg;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= 16'hACE1;
    end else if (accept) begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
    end
  end

  // Current LFSR value sets this access's extra wait before the register steps.
  assign wait_total = 5'(LATENCY) + {3'b000, lfsr_reg[1:0]};
`else
  assign wait_total = 5'(LATENCY);
`endif

  // Capture view: with zero latency RESP is entered on the accepting edge, so
  // error, index and RAM address must come from the incoming request.
  assign addr_next  = accept ? daddr  : addr_reg;
  assign size_next  = accept ? dsize  : size_reg;
  assign write_next = accept ? dwrite : write_reg;
  assign wdata_next = (accept && dwrite) ? ddata : wdata_reg;
  assign off_next   = addr_next - BASE_ADDR;
  assign idx_next   = off_next[DEPTH_LOG2+1:2];
  assign err_next   = (size_next == 2'b11)
                   || ((size_next == 2'b01) && addr_next[0])
                   || ((size_next == 2'b10) && (addr_next[1:0] != 2'b00))
                   || ({1'b0, off_next} >= MEM_BYTES);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (dreq) begin
          if (wait_total == 5'd0) begin
            state_next = RESP;
          end else begin
            state_next = BUSY;
            cnt_next   = wait_total - 5'd1;
          end
        end
      end
      BUSY: begin
        if (cnt_reg == 5'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 5'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign resp_entry = (state_next == RESP) && (state_reg != RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 5'd0;
      addr_reg     <= 32'd0;
      size_reg     <= 2'b00;
      write_reg    <= 1'b0;
      wdata_reg    <= 32'd0;
      err_reg      <= 1'b0;
      idx_reg      <= '0;
      dready_n_reg <= 1'b1;
      dbusy_reg    <= 1'b0;
      derr_reg     <= 1'b0;
      drive_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      addr_reg     <= addr_next;
      size_reg     <= size_next;
      write_reg    <= write_next;
      wdata_reg    <= wdata_next;
      err_reg      <= err_next;
      idx_reg      <= idx_next;
      dready_n_reg <= (state_next != RESP);
      dbusy_reg    <= (state_next != IDLE);
      derr_reg     <= (state_next == RESP) && err_next;
      drive_reg    <= (state_next == RESP) && !write_next;
    end
  end

  // Lane enables and lane-replicated write data.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign be[gi] = (size_reg == 2'b10)
                   || ((size_reg == 2'b01) && (addr_reg[1] == LANE[1]))
                   || ((size_reg == 2'b00) && (addr_reg[1:0] == LANE));
      assign wlane[8*gi +: 8] = (size_reg == 2'b10) ? wdata_reg[8*gi +: 8]
                              : (size_reg == 2'b01) ? wdata_reg[8*(gi%2) +: 8]
                              :                       wdata_reg[7:0];
    end
  endgenerate

  // Commit happens on the edge leaving RESP; a reset on that edge cancels it.
  assign commit = (state_reg == RESP) && write_reg && !err_reg && !rst;

  always_ff @(posedge clk) begin
    if (resp_entry) begin
      rd_word_reg <= mem[idx_next];
    end
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx_reg][8*i +: 8] <= wlane[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (!err_reg) begin
      unique case (size_reg)
        2'b00:   rdata = (rd_word_reg >> {addr_reg[1:0], 3'b000}) & 32'h0000_00FF;
        2'b01:   rdata = (rd_word_reg >> {addr_reg[1], 4'b0000}) & 32'h0000_FFFF;
        default: rdata = rd_word_reg;
      endcase
    end
  end

  assign ddata    = drive_reg ? rdata : 32'bz;
  assign dready_n = dready_n_reg;
  assign dbusy    = dbusy_reg;
  assign derr     = derr_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: data path, errors, latency 0/1/3 and abort-on-reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  dreq_v = 3'b000;
  logic [2:0]  drv_v  = 3'b000;
  logic        dwrite = 1'b0;
  logic [31:0] daddr  = 32'd0;
  logic [1:0]  dsize  = 2'b10;
  logic [31:0] wdata  = 32'd0;

  wire  [31:0] bus0, bus1, bus2;
  logic        rdy0, rdy1, rdy2;
  logic        busy0, busy1, busy2;
  logic        err0, err1, err2;

  int total = 0;
  int bad   = 0;

  assign bus0 = drv_v[0] ? wdata : 32'bz;
  assign bus1 = drv_v[1] ? wdata : 32'bz;
  assign bus2 = drv_v[2] ? wdata : 32'bz;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(32'h0), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .dreq(dreq_v[0]), .dwrite(dwrite), .daddr(daddr),
    .dsize(dsize), .ddata(bus0), .dready_n(rdy0), .dbusy(busy0), .derr(err0)
  );

  dmem_responder #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst), .dreq(dreq_v[1]), .dwrite(dwrite), .daddr(daddr),
    .dsize(dsize), .ddata(bus1), .dready_n(rdy1), .dbusy(busy1), .derr(err1)
  );

  dmem_responder #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst(rst), .dreq(dreq_v[2]), .dwrite(dwrite), .daddr(daddr),
    .dsize(dsize), .ddata(bus2), .dready_n(rdy2), .dbusy(busy2), .derr(err2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sample(input int u, output logic r, output logic b, output logic e,
                        output logic [31:0] d);
    case (u)
      0:       begin r = rdy0; b = busy0; e = err0; d = bus0; end
      1:       begin r = rdy1; b = busy1; e = err1; d = bus1; end
      default: begin r = rdy2; b = busy2; e = err2; d = bus2; end
    endcase
  endtask

  // One complete handshake on unit u; returns response data, error, latency and busy width.
  task automatic access(input int u, input logic wr, input logic [31:0] a,
                        input logic [1:0] sz, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int bcnt);
    logic r, b, e;
    logic [31:0] d;
    int cyc;
    bit done;
    @(negedge clk);
    dwrite = wr; daddr = a; dsize = sz; wdata = wd;
    drv_v[u] = wr; dreq_v[u] = 1'b1;
    @(posedge clk);
    cyc = 0; bcnt = 0; done = 0; rd = 32'd0; er = 1'b0; lat = -1;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      sample(u, r, b, e, d);
      if (b) bcnt++;
      if (!r) begin
        done = 1; lat = cyc; rd = d; er = e;
        dreq_v[u] = 1'b0; drv_v[u] = 1'b0;
      end
    end
    if (!done) begin
      dreq_v[u] = 1'b0; drv_v[u] = 1'b0;
      chk("timeout", 32'd0, 32'd1);
    end
    @(negedge clk);
    sample(u, r, b, e, d);
    chk("pulse_width", {31'd0, r}, 32'd1);
    chk("busy_after", {31'd0, b}, 32'd0);
    $display("txn u=%0d wr=%0d addr=%h size=%0d rd=%h err=%0d lat=%0d busy=%0d",
             u, wr, a, sz, rd, er, lat, bcnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic er;
    int lat, bc;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_dready_n", {31'd0, rdy0}, 32'd1);
    chk("rst_dbusy",    {31'd0, busy0}, 32'd0);
    chk("rst_derr",     {31'd0, err0}, 32'd0);

    // Word write then read back.
    access(0, 1'b1, 32'h100, 2'b10, 32'hDEADBEEF, rd, er, lat, bc);
    chk("w100_err", {31'd0, er}, 32'd0);
    chk("w100_lat", lat, 32'd2);
    access(0, 1'b0, 32'h100, 2'b10, 32'h0, rd, er, lat, bc);
    chk("r100_data", rd, 32'hDEADBEEF);
    chk("r100_err", {31'd0, er}, 32'd0);
    chk("r100_lat", lat, 32'd2);
    chk("r100_busy", bc, 32'd2);

    // Byte merge and sub-word reads.
    access(0, 1'b1, 32'h100, 2'b10, 32'h11223344, rd, er, lat, bc);
    access(0, 1'b1, 32'h103, 2'b00, 32'h0000005A, rd, er, lat, bc);
    chk("wb103_err", {31'd0, er}, 32'd0);
    access(0, 1'b0, 32'h100, 2'b10, 32'h0, rd, er, lat, bc);
    chk("merge_word", rd, 32'h5A223344);
    access(0, 1'b0, 32'h102, 2'b01, 32'h0, rd, er, lat, bc);
    chk("half_102", rd, 32'h00005A22);
    access(0, 1'b0, 32'h101, 2'b00, 32'h0, rd, er, lat, bc);
    chk("byte_101", rd, 32'h00000033);
    access(0, 1'b0, 32'h100, 2'b01, 32'h0, rd, er, lat, bc);
    chk("half_100", rd, 32'h00003344);

    // Misalignment errors.
    access(0, 1'b0, 32'h101, 2'b01, 32'h0, rd, er, lat, bc);
    chk("half_101_err", {31'd0, er}, 32'd1);
    chk("half_101_data", rd, 32'h0);
    access(0, 1'b1, 32'h102, 2'b10, 32'hAAAAAAAA, rd, er, lat, bc);
    chk("word_102_err", {31'd0, er}, 32'd1);
    access(0, 1'b0, 32'h100, 2'b10, 32'h0, rd, er, lat, bc);
    chk("after_bad_wr", rd, 32'h5A223344);
    chk("after_bad_err", {31'd0, er}, 32'd0);

    // Out-of-range and reserved size.
    access(0, 1'b0, 32'h4000, 2'b10, 32'h0, rd, er, lat, bc);
    chk("range_err", {31'd0, er}, 32'd1);
    chk("range_data", rd, 32'h0);
    access(0, 1'b0, 32'h100, 2'b11, 32'h0, rd, er, lat, bc);
    chk("size11_err", {31'd0, er}, 32'd1);
    chk("size11_data", rd, 32'h0);
    access(0, 1'b0, 32'h3FFC, 2'b10, 32'h0, rd, er, lat, bc);
    chk("last_word_err", {31'd0, er}, 32'd0);

    // Latency sweep.
    access(1, 1'b1, 32'h8, 2'b10, 32'h12345678, rd, er, lat, bc);
    chk("l0_w_lat", lat, 32'd1);
    access(1, 1'b0, 32'h8, 2'b10, 32'h0, rd, er, lat, bc);
    chk("l0_r_data", rd, 32'h12345678);
    chk("l0_r_lat", lat, 32'd1);
    chk("l0_r_busy", bc, 32'd1);
    access(2, 1'b1, 32'h4, 2'b10, 32'hCAFEF00D, rd, er, lat, bc);
    chk("l3_w_lat", lat, 32'd4);
    access(2, 1'b0, 32'h4, 2'b10, 32'h0, rd, er, lat, bc);
    chk("l3_r_data", rd, 32'hCAFEF00D);
    chk("l3_r_lat", lat, 32'd4);
    chk("l3_r_busy", bc, 32'd4);

    // Reset during BUSY aborts a pending write.
    access(0, 1'b1, 32'h200, 2'b10, 32'h0, rd, er, lat, bc);
    @(negedge clk);
    dwrite = 1'b1; daddr = 32'h200; dsize = 2'b10; wdata = 32'hFFFFFFFF;
    drv_v[0] = 1'b1; dreq_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_in_busy", {31'd0, busy0}, 32'd1);
    rst = 1'b1; dreq_v[0] = 1'b0; drv_v[0] = 1'b0;
    @(negedge clk);
    chk("abort_dready_n", {31'd0, rdy0}, 32'd1);
    chk("abort_dbusy", {31'd0, busy0}, 32'd0);
    chk("abort_derr", {31'd0, err0}, 32'd0);
    rst = 1'b0;
    $display("txn u=0 reset abort of write addr=00000200");
    access(0, 1'b0, 32'h200, 2'b10, 32'h0, rd, er, lat, bc);
    chk("abort_mem", rd, 32'h0);
    access(0, 1'b0, 32'h100, 2'b10, 32'h0, rd, er, lat, bc);
    chk("retained_mem", rd, 32'h5A223344);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-bus responder for the 5-stage RV32I core: the memory-side end of the `daddr`/`dsize`/`dreq`/`dwrite`/`ddata`/`dready_n`/`dbusy` interface the core's memory-access stage initiates. It accepts one request at a time, holds `dbusy` through a configurable wait period, and completes each access with a single-cycle `dready_n` low pulse. Reads drive `ddata`; writes merge bytes into an internal word-organised array. It replaces the behavioural data memory in core-level simulation and serves as the on-chip data RAM.

## Interface
Parameters:
- `DEPTH_LOG2`, 12: log2 of array depth in 32-bit words (16 KiB default).
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0.
- `LATENCY`, 1: wait cycles between acceptance and response, 0..15.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk` input 1: clock; all state changes on the rising edge.
  - `rst` input 1: synchronous, active-high reset.
- `dreq` input 1: request valid; held by the core until it samples `dready_n` low.
- `dwrite` input 1: 1 = write, 0 = read.
- `daddr` input 32: byte address.
- `dsize` input 2: access size; 00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- `ddata` inout 32: write data from the core; read data from this block.
- `dready_n` output 1: active-low completion strobe, exactly one cycle per access.
- `dbusy` output 1: access in progress.
- `derr` output 1: error flag, valid only while `dready_n` = 0.

## Operation
- Three-state FSM: IDLE, BUSY and RESP.
- IDLE:
  - Sample `dreq`. When it is 1, capture `daddr`, `dsize`, `dwrite` and, for writes, `ddata`.
  - Next state is BUSY with the wait counter set to `LATENCY`-1, or RESP if `LATENCY` = 0.
- BUSY: decrement the counter; move to RESP when it reaches 0.
- RESP:
  - Assert `dready_n` = 0 for one cycle, then return to IDLE.
  - `dreq` is ignored in RESP.
- Error check on the captured request. Any error sets `derr` = 1 for the RESP cycle; a write is dropped and a read returns 0. Errors are:
  - `dsize` = 11.
  - Misalignment: halfword with `addr[0]`, or word with `addr[1:0]` ≠ 0.
  - `addr` − `BASE_ADDR` ≥ 4·2^`DEPTH_LOG2` (unsigned 32-bit subtract).
- Word index is (`addr` − `BASE_ADDR`)[`DEPTH_LOG2`+1:2]. Lane is `addr[1:0]`.
- Write: at the end of the RESP cycle, merge only the addressed bytes into the array.
  - Byte: `wdata[7:0]` → lane `addr[1:0]`.
  - Halfword: `wdata[15:0]` → lanes `addr[1]`·2 and `addr[1]`·2+1.
  - Word: all four lanes.
- Read:
  - Data is right-justified and zero-extended. Byte is `mem[idx] >> 8·addr[1:0]` masked to 8 bits; halfword is shifted by 16·`addr[1]` and masked to 16 bits. Sign extension is the core's job.
  - The array is read on RESP entry, so a read always observes every previously completed write.
- `ddata` is driven only during RESP of a read; high-Z otherwise, including RESP of a write.
- Reset:
  - Forces IDLE and clears the counter and captured fields.
  - Outputs: `dready_n` = 1, `dbusy` = 0, `derr` = 0, `ddata` = Z.
  - Array contents are retained.
  - Reset during BUSY or RESP aborts the access; a pending write is not committed.

## Timing
- Acceptance at edge E0, when IDLE and `dreq` = 1.
- `dbusy` = 1 from E0 until the edge leaving RESP; high in BUSY and RESP, low in IDLE.
- `dready_n` is low in cycle E0 + `LATENCY` + 1, i.e. request-to-response latency is `LATENCY`+1 cycles.
  - `LATENCY` = 0: `dready_n` low in the cycle right after acceptance.
- The core drops or renews `dreq` at the edge where it samples `dready_n` low. The IDLE cycle after RESP may accept a new request immediately.
- Minimum issue interval is `LATENCY`+2 cycles.
- A write followed back-to-back by a read to the same address returns the new data.
- All outputs are registered; no combinational path from inputs to `dready_n`, `dbusy` or `derr`.

## Configuration
- `DMEM_RANDLAT_EN`
  - Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances once per acceptance, and that access's wait count is `LATENCY` + `lfsr[1:0]`. This stresses core stall handling.
  - Undefined: the LFSR is absent and the latency is exactly `LATENCY`+1 for every access.

## Test plan
- Word write `daddr` = 0x100, `ddata` = 0xDEADBEEF, then word read at 0x100 → `ddata` = 0xDEADBEEF, `derr` = 0, each `dready_n` pulse exactly 1 cycle wide.
- Byte write 0x5A to 0x103 over word 0x11223344, then word read → 0x5A223344. Halfword read at 0x102 → 0x00005A22.
- Halfword read at 0x101 → `derr` = 1, `ddata` = 0. Word write at 0x102 → `derr` = 1 and memory unchanged.
- Latency sweep with `DMEM_RANDLAT_EN` undefined:
  - `LATENCY` = 0: `dready_n` low 1 cycle after acceptance.
  - `LATENCY` = 3: `dready_n` low 4 cycles after acceptance, `dbusy` high for 4 cycles.
- Assert `rst` during BUSY of a word write of 0xFFFFFFFF to a location holding 0x0 → all outputs at reset values the next cycle; a later read returns 0x0.
- Read at `BASE_ADDR` + 4·2^`DEPTH_LOG2` → `derr` = 1, `ddata` = 0. The `dsize` = 11 request gets the same response.
